// File: rtl/map_ram_arbiter.sv
// Tile-map RAM arbiter. A single-port RAM is shared by three agents: the VGA
// renderer, a clear sequencer and the game logic.
// Priority is renderer > clear > game. The arbitration result is registered
// onto mem_*. Read data comes back one cycle later and is tagged to its requester.
module map_ram_arbiter #(
  parameter int unsigned MAP_W          = 40,
  parameter int unsigned MAP_H          = 30,
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CLEAR_TILE     = 0,
  parameter bit          VBLANK_WR_ONLY = 1'b1,
  parameter int unsigned STARVE_LIMIT   = 1023
) (
  input  logic              clk,
  input  logic              rstn,
  // renderer
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  // game logic
  input  logic              g_valid,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_ready,
  output logic [DATA_W-1:0] g_rdata,
  output logic              g_rvalid,
  // control / status
  input  logic              vblank,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              starve,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       MapCells  = MAP_W * MAP_H;
  localparam int unsigned       StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(MapCells - 1);
  localparam logic [ADDR_W:0]   CellsExt  = (ADDR_W + 1)'(MapCells);
  localparam logic [DATA_W-1:0] ClearTile = DATA_W'(CLEAR_TILE);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clear_done_q, clear_done_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  // Read tags travel alongside the command on mem_*, then become the valid strobes.
  logic                rd_r_q, rd_r_d;
  logic                rd_g_q, rd_g_d;
  logic                r_valid_q, g_rvalid_q;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic                starve_q, starve_d;
  logic                g_fire;

  // Game grant is purely combinational and independent of g_valid.
  always_comb begin
    g_ready = !r_req && (state_q == StIdle) && !clear_start &&
              (!g_we || !VBLANK_WR_ONLY || vblank);
    g_fire  = g_valid && g_ready;
  end

  // Arbitration, clear FSM next-state and the next RAM command.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clear_done_d = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_r_d       = 1'b0;
    rd_g_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        // The renderer pre-empts the sequencer; the counter only moves on a write.
        if (!r_req) begin
          if (clr_cnt_q == LastAddr) begin
            state_d      = StIdle;
            clr_cnt_d    = '0;
            clear_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (r_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = r_addr;
      rd_r_d     = 1'b1;
    end else if (state_q == StClear) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_cnt_q;
      mem_wdata_d = ClearTile;
    end else if (g_fire) begin
      if (!g_we) begin
        mem_en_d   = 1'b1;
        mem_addr_d = g_addr;
        rd_g_d     = 1'b1;
      end else if ({1'b0, g_addr} < CellsExt) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = g_addr;
        mem_wdata_d = g_wdata;
      end
      // Out-of-range writes complete the handshake but never reach the RAM.
    end
  end

  // Starvation watchdog: counts consecutive stalled game cycles; the flag is sticky.
  always_comb begin
    starve_cnt_d = '0;
    if (g_valid && !g_ready) begin
      starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
    starve_d = starve_q || (starve_cnt_d == StarveMax);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_r_q       <= 1'b0;
      rd_g_q       <= 1'b0;
      r_valid_q    <= 1'b0;
      g_rvalid_q   <= 1'b0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_done_q <= clear_done_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_r_q       <= rd_r_d;
      rd_g_q       <= rd_g_d;
      r_valid_q    <= rd_r_q;
      g_rvalid_q   <= rd_g_q;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  // Output mapping.
  always_comb begin
    mem_en     = mem_en_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    r_data     = mem_rdata;
    g_rdata    = mem_rdata;
    r_valid    = r_valid_q;
    g_rvalid   = g_rvalid_q;
    clear_busy = (state_q == StClear);
    clear_done = clear_done_q;
    starve     = starve_q;
  end

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter with a small synchronous RAM model.
module tb_map_ram_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          r_req = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          g_valid = 1'b0;
  logic          g_we = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  logic          g_ready;
  logic [DW-1:0] g_rdata;
  logic          g_rvalid;
  logic          vblank = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          clear_done;
  logic          starve;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int passed = 0;
  int total  = 0;

  // clear / read bookkeeping
  int wr_cnt, wr_bad, rv_cnt, issued, done_cnt, busy_bad, both_cnt;

  map_ram_arbiter #(
    .MAP_W(40), .MAP_H(30), .ADDR_W(AW), .DATA_W(DW),
    .CLEAR_TILE(0), .VBLANK_WR_ONLY(1'b1), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .r_req(r_req), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .g_valid(g_valid), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_ready(g_ready), .g_rdata(g_rdata), .g_rvalid(g_rvalid),
    .vblank(vblank), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .starve(starve),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten cells read back as addr & 0xFF.
  logic [DW-1:0] ram [0:2047];
  bit            written [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (mem_en && mem_we) begin
      if (mem_addr != AW'(wr_cnt) || mem_wdata != 8'h00) wr_bad++;
      wr_cnt++;
    end
    if (r_valid) rv_cnt++;
    if (r_valid && g_rvalid) both_cnt++;
    if (clear_done) begin
      done_cnt++;
      if (clear_busy) busy_bad++;
    end
  endtask

  initial begin
    // ---- reset state
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_starve", starve, 0);
    @(negedge clk);
    rstn = 1'b1;
    vblank = 1'b1;
    @(negedge clk);

    // ---- 1: renderer burst 0..7
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        chk("t1_r_valid", r_valid, 1);
        chk("t1_r_data", r_data, i - 2);
        chk("t1_g_rvalid", g_rvalid, 0);
      end else begin
        chk("t1_r_valid_early", r_valid, 0);
      end
      r_req  = (i < 8);
      r_addr = AW'(i);
      #1;
      chk("t1_g_ready", g_ready, (i < 8) ? 0 : 1);
      @(negedge clk);
    end
    r_req = 1'b0;

    // ---- 2: game write 0xA7 @5 then read back
    g_valid = 1'b1; g_we = 1'b1; g_addr = 11'd5; g_wdata = 8'hA7;
    #1 chk("t2_wr_ready", g_ready, 1);
    @(negedge clk);
    chk("t2_mem_en", mem_en, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_addr", mem_addr, 5);
    chk("t2_mem_wdata", mem_wdata, 8'hA7);
    g_we = 1'b0;
    #1 chk("t2_rd_ready", g_ready, 1);
    @(negedge clk);
    chk("t2_rd_mem_we", mem_we, 0);
    chk("t2_rd_mem_en", mem_en, 1);
    chk("t2_rvalid_n1", g_rvalid, 0);
    g_valid = 1'b0;
    @(negedge clk);
    chk("t2_g_rvalid", g_rvalid, 1);
    chk("t2_g_rdata", g_rdata, 8'hA7);
    chk("t2_r_valid", r_valid, 0);

    // ---- 3: vblank gating of writes
    vblank = 1'b0;
    g_valid = 1'b1; g_we = 1'b1; g_addr = 11'd9; g_wdata = 8'h3C;
    #1 chk("t3_wr_blocked", g_ready, 0);
    @(negedge clk);
    chk("t3_no_cmd", mem_en, 0);
    g_we = 1'b0; g_addr = 11'd5;
    #1 chk("t3_rd_ok", g_ready, 1);
    @(negedge clk);
    chk("t3_rd_mem_en", mem_en, 1);
    chk("t3_rd_mem_we", mem_we, 0);
    g_we = 1'b1; g_addr = 11'd9;
    #1 chk("t3_wr_blocked2", g_ready, 0);
    vblank = 1'b1;
    #1 chk("t3_wr_granted", g_ready, 1);
    @(negedge clk);
    chk("t3_wr_mem_we", mem_we, 1);
    chk("t3_wr_mem_addr", mem_addr, 9);
    chk("t3_wr_mem_wdata", mem_wdata, 8'h3C);
    g_valid = 1'b0; g_we = 1'b0; vblank = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // ---- 4: full clear with renderer toggling
    wr_cnt = 0; wr_bad = 0; rv_cnt = 0; issued = 0; done_cnt = 0; busy_bad = 0; both_cnt = 0;
    clear_start = 1'b1;
    #1 chk("t4_g_ready_start", g_ready, 0);
    @(negedge clk);
    clear_start = 1'b0;
    chk("t4_busy", clear_busy, 1);
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      r_req       = (c % 2 == 1);
      r_addr      = AW'(c);
      clear_start = (c == 50);
      if (r_req) issued++;
      @(negedge clk);
      observe();
    end
    r_req = 1'b0; clear_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      observe();
    end
    chk("t4_write_count", wr_cnt, 1200);
    chk("t4_write_bad", wr_bad, 0);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_busy_at_done", busy_bad, 0);
    chk("t4_reads_returned", rv_cnt, issued);
    chk("t4_both_valid", both_cnt, 0);
    chk("t4_busy_end", clear_busy, 0);

    // ---- 5: reset mid-clear with a read in flight
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 11'd599) break;
    end
    chk("t5_reached_599", mem_addr, 599);
    r_req = 1'b1; r_addr = 11'd3;
    @(negedge clk);
    chk("t5_rd_issued", mem_en & ~mem_we, 1);
    chk("t5_busy_before", clear_busy, 1);
    r_req = 1'b0;
    rstn = 1'b0;
    #1;
    chk("t5_mem_en", mem_en, 0);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_mem_wdata", mem_wdata, 0);
    chk("t5_busy", clear_busy, 0);
    chk("t5_done", clear_done, 0);
    chk("t5_r_valid", r_valid, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_rst_r_valid", r_valid, 0);
      chk("t5_rst_g_rvalid", g_rvalid, 0);
    end
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_post_r_valid", r_valid, 0);
      chk("t5_post_done", clear_done, 0);
      chk("t5_post_busy", clear_busy, 0);
      chk("t5_post_mem_en", mem_en, 0);
    end
    #1 chk("t5_idle_ready", g_ready, 1);

    // ---- 6: starvation, then an out-of-range write
    g_valid = 1'b1; g_we = 1'b1; g_addr = 11'd1200; g_wdata = 8'h55; vblank = 1'b1;
    r_req = 1'b1; r_addr = 11'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) chk("t6_starve_early", starve, 0);
    end
    chk("t6_starve_set", starve, 1);
    r_req = 1'b0;
    #1 chk("t6_oob_ready", g_ready, 1);
    @(negedge clk);
    chk("t6_oob_mem_en", mem_en, 0);
    chk("t6_oob_mem_we", mem_we, 0);
    chk("t6_starve_sticky", starve, 1);
    g_valid = 1'b0;
    @(negedge clk);
    chk("t6_starve_sticky2", starve, 1);
    chk("t6_idle_mem_en", mem_en, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
